// File: rtl/bus_demux_pkg.sv
// Shared definitions for the write-side bus demultiplexer: FSM states,
// channel select codes, the settle counter width and the strobe decoder.
package bus_demux_pkg;

  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;
  localparam logic [1:0] SEL_CH3 = 2'b11;

  // One-hot strobe pattern for a channel select code.
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    logic [3:0] oh;
    case (sel)
      SEL_CH0: oh = 4'b0001;
      SEL_CH1: oh = 4'b0010;
      SEL_CH2: oh = 4'b0100;
      SEL_CH3: oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bus_demux_ctrl_settle_timer.sv
// Down-counter that times the settle interval following an accepted write.
// done is raised in the last cycle of the interval.
module settle_timer
  import bus_demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done,
  output logic             running
);

  logic [CNT_W-1:0] cnt_r;
  logic             running_r;

  // Reload only on accept, so the counter can never wrap below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      running_r <= 1'b0;
    end else if (load) begin
      cnt_r     <= load_val;
      running_r <= 1'b1;
    end else if (running_r) begin
      if (cnt_r == {CNT_W{1'b0}}) begin
        running_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end else begin
      cnt_r     <= cnt_r;
      running_r <= running_r;
    end
  end

  assign done    = running_r && (cnt_r == {CNT_W{1'b0}});
  assign running = running_r;

endmodule

// File: rtl/bus_demux_ctrl.sv
// Routes one write word to one of four registered channels selected by {s1,s0},
// pulsing a per-channel strobe and blocking further writes for SETTLE_CYCLES.
module bus_demux_ctrl
  import bus_demux_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [3:0]       stb,
  output logic             busy
);

  localparam logic             HAS_SETTLE = (SETTLE_CYCLES != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] LOAD_VAL   =
    (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : {CNT_W{1'b0}};

  state_t           state_r;
  logic [WIDTH-1:0] ch_r [4];
  logic [3:0]       stb_r;
  logic [1:0]       sel_s;
  logic             accept_s;
  logic             load_s;
  logic             timer_done_s;
  logic             timer_running_s;

  assign sel_s    = {s1, s0};
  assign accept_s = in_valid && (state_r == ST_IDLE);
  assign load_s   = accept_s && HAS_SETTLE;

  settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (LOAD_VAL),
    .done     (timer_done_s),
    .running  (timer_running_s)
  );

  // FSM, channel registers and strobe; a stalled timer in SETTLE falls back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      stb_r   <= 4'b0000;
      for (int n = 0; n < 4; n++) begin
        ch_r[n] <= {WIDTH{1'b0}};
      end
    end else begin
      stb_r <= 4'b0000;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            ch_r[sel_s] <= i;
            stb_r       <= sel_onehot(sel_s);
            state_r     <= HAS_SETTLE ? ST_SETTLE : ST_IDLE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (timer_done_s || !timer_running_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_SETTLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = (state_r == ST_IDLE);
  assign busy     = (state_r == ST_SETTLE);
  assign stb      = stb_r;
  assign o0       = ch_r[0];
  assign o1       = ch_r[1];
  assign o2       = ch_r[2];
  assign o3       = ch_r[3];

endmodule

// File: tb/tb_bus_demux_ctrl.sv
// Bench for bus_demux_ctrl: instance 0 has SETTLE_CYCLES=3, instance 1 has 0.
// A transaction-level model is compared against both every cycle.
module tb_bus_demux_ctrl;

  localparam int W = 4;
  localparam int SET [2] = '{3, 0};

  logic         clk = 1'b0;
  logic         rst;
  logic         valid [2];
  logic [1:0]   sel   [2];
  logic [W-1:0] data  [2];
  logic         d_ready [2];
  logic         d_busy  [2];
  logic [3:0]   d_stb   [2];
  logic [W-1:0] d_o [2][4];

  // Reference model state
  logic [W-1:0] m_o   [2][4];
  logic [3:0]   m_stb [2];
  int           m_blk [2];
  bit           started = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_demux_ctrl #(.WIDTH(W), .SETTLE_CYCLES(3)) u_a (
    .clk(clk), .rst(rst), .in_valid(valid[0]), .in_ready(d_ready[0]),
    .s0(sel[0][0]), .s1(sel[0][1]), .i(data[0]),
    .o0(d_o[0][0]), .o1(d_o[0][1]), .o2(d_o[0][2]), .o3(d_o[0][3]),
    .stb(d_stb[0]), .busy(d_busy[0])
  );

  bus_demux_ctrl #(.WIDTH(W), .SETTLE_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(valid[1]), .in_ready(d_ready[1]),
    .s0(sel[1][0]), .s1(sel[1][1]), .i(data[1]),
    .o0(d_o[1][0]), .o1(d_o[1][1]), .o2(d_o[1][2]), .o3(d_o[1][3]),
    .stb(d_stb[1]), .busy(d_busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: a write is taken when valid and no ready-low cycles remain.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int c = 0; c < 4; c++) m_o[k][c] = '0;
        m_stb[k] = 4'b0000;
        m_blk[k] = 0;
      end else if (valid[k] && m_blk[k] == 0) begin
        m_o[k][sel[k]] = data[k];
        m_stb[k] = 4'(1 << sel[k]);
        m_blk[k] = SET[k];
      end else begin
        m_stb[k] = 4'b0000;
        if (m_blk[k] > 0) m_blk[k] = m_blk[k] - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 4; c++)
          check($sformatf("u%0d_o%0d", k, c), 32'(d_o[k][c]), 32'(m_o[k][c]));
        check($sformatf("u%0d_stb", k), 32'(d_stb[k]), 32'(m_stb[k]));
        check($sformatf("u%0d_ready", k), 32'(d_ready[k]), 32'(m_blk[k] == 0));
        check($sformatf("u%0d_busy", k), 32'(d_busy[k]), 32'(m_blk[k] != 0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      valid[k] = 1'b0; sel[k] = 2'b00; data[k] = '0;
    end
    tick();
    started = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_o0", 32'(d_o[0][0]), 32'h0);
    check("rst_o3", 32'(d_o[0][3]), 32'h0);
    check("rst_stb", 32'(d_stb[0]), 32'h0);
    check("rst_ready", 32'(d_ready[0]), 32'h1);
    check("rst_busy", 32'(d_busy[0]), 32'h0);

    // Single write ch2=A, then measure ready-low span
    valid[0] = 1'b1; sel[0] = 2'b10; data[0] = 4'hA;
    tick();
    valid[0] = 1'b0;
    check("single_o2", 32'(d_o[0][2]), 32'hA);
    check("single_stb", 32'(d_stb[0]), 32'h4);
    n = 0;
    while (!d_ready[0] && n < 10) begin n++; tick(); end
    check("single_lowcnt", 32'(n), 32'd3);

    // Held request ch1=5, settle-time garbage ch0=7, then ch3=C
    valid[0] = 1'b1; sel[0] = 2'b01; data[0] = 4'h5;
    tick();
    sel[0] = 2'b00; data[0] = 4'h7;
    tick();
    sel[0] = 2'b11; data[0] = 4'hC;
    n = 1;
    while (d_stb[0] != 4'b1000 && n < 20) begin tick(); n++; end
    valid[0] = 1'b0;
    check("b2b_edges", 32'(n), 32'd4);
    check("b2b_o1", 32'(d_o[0][1]), 32'h5);
    check("b2b_o3", 32'(d_o[0][3]), 32'hC);
    check("b2b_o0", 32'(d_o[0][0]), 32'h0);
    n = 0;
    while (!d_ready[0] && n < 10) begin n++; tick(); end
    check("b2b_idle_to", 32'(n < 10), 32'h1);

    // Reset in the second settle cycle
    valid[0] = 1'b1; sel[0] = 2'b00; data[0] = 4'hF;
    tick();
    valid[0] = 1'b0;
    check("mid_o0_pre", 32'(d_o[0][0]), 32'hF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_o0", 32'(d_o[0][0]), 32'h0);
    check("mid_ready", 32'(d_ready[0]), 32'h1);
    check("mid_busy", 32'(d_busy[0]), 32'h0);
    valid[0] = 1'b1; sel[0] = 2'b00; data[0] = 4'h6;
    tick();
    valid[0] = 1'b0;
    check("mid_o0_new", 32'(d_o[0][0]), 32'h6);
    check("mid_stb_new", 32'(d_stb[0]), 32'h1);
    n = 0;
    while (!d_ready[0] && n < 10) begin n++; tick(); end

    // Overwrite ch2: 3 then 9
    valid[0] = 1'b1; sel[0] = 2'b10; data[0] = 4'h3;
    tick();
    pulses = (d_stb[0] == 4'b0100) ? 1 : 0;
    data[0] = 4'h9;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (d_stb[0] == 4'b0100) begin pulses++; valid[0] = 1'b0; end
    end
    valid[0] = 1'b0;
    check("ovw_pulses", 32'(pulses), 32'd2);
    check("ovw_o2", 32'(d_o[0][2]), 32'h9);
    check("ovw_o0", 32'(d_o[0][0]), 32'h6);
    check("ovw_o1", 32'(d_o[0][1]), 32'h0);

    // Zero settle: one write per cycle across all channels
    valid[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sel[1] = 2'(c); data[1] = 4'(c + 1);
      tick();
      check($sformatf("z_stb%0d", c), 32'(d_stb[1]), 32'(1 << c));
      check($sformatf("z_ready%0d", c), 32'(d_ready[1]), 32'h1);
    end
    valid[1] = 1'b0;
    tick();
    for (int c = 0; c < 4; c++)
      check($sformatf("z_o%0d", c), 32'(d_o[1][c]), 32'(c + 1));
    check("z_stb_idle", 32'(d_stb[1]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_demux_ctrl.md
Name: bus_demux_ctrl

Overview:
Write-side counterpart of the 4:1 data-bus mux: routes one input word to one of four registered output channels, selected by {s1,s0}.
Writes use a valid/ready handshake. Each accepted write pulses a per-channel strobe, then enforces a programmable settle interval before the next write is accepted.
Sits between the controller and the four valve/zone registers of the sprinkler data bus.

Parameters:
WIDTH, 4, data word width of the input and of each output channel
SETTLE_CYCLES, 3, cycles in_ready stays low after an accepted write; 0 means back-to-back writes allowed; legal range 0..255

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  initiator has a write pending
in_ready  output  1  block can accept a write this cycle
s0  input  1  channel select LSB
s1  input  1  channel select MSB
i  input  WIDTH  write data
o0  output  WIDTH  channel 0 register, selected by {s1,s0}=00
o1  output  WIDTH  channel 1 register, selected by 01
o2  output  WIDTH  channel 2 register, selected by 10
o3  output  WIDTH  channel 3 register, selected by 11
stb  output  4  one-hot, one-cycle write strobe; bit n = channel n
busy  output  1  high while in settle interval

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: o0..o3 = 0, stb = 0, busy = 0, state = IDLE, counter = 0. in_ready = 1 in the cycle after reset.
- FSM has two states, IDLE and SETTLE.
- in_ready = (state==IDLE), decoded combinationally from state only. busy = (state==SETTLE).
- Accept condition: in_valid && in_ready at a rising edge.
- On accept:
  - o[{s1,s0}] <= i; the other three channels hold.
  - stb <= 4'b0001 << {s1,s0} for exactly one cycle.
- Latency: new channel value and strobe are visible the cycle after the accept edge. stb = 0 in every cycle that does not follow an accept.
- Transitions:
  - IDLE, accept, SETTLE_CYCLES>0: go to SETTLE, cnt <= SETTLE_CYCLES-1.
  - IDLE, accept, SETTLE_CYCLES=0: stay in IDLE. A write can be accepted every cycle.
  - SETTLE, cnt!=0: cnt decrements.
  - SETTLE, cnt==0: go to IDLE.
  - Net effect: in_ready is low for exactly SETTLE_CYCLES cycles after each accept cycle.
- in_valid, s0, s1 and i are ignored while in SETTLE. There is no queuing; the initiator holds its request until in_ready.
- Select lines and data are sampled only on the accept edge. Changes at other times have no effect.
- Writing the same channel twice overwrites it and produces a new strobe.
- Reset mid-settle: return to IDLE with all outputs cleared. Any partially timed interval is discarded.
- rst has priority over accept in the same cycle.
- Counter width is 8 bits. It never wraps, because it reloads only from IDLE.

Decomposition:
- Shared package bus_demux_pkg holds:
  - state encoding constants ST_IDLE, ST_SETTLE
  - channel select constants SEL_CH0..SEL_CH3 (2'b00..2'b11)
  - counter width constant CNT_W = 8
- One natural sub-module, settle_timer. Inputs: clk, rst, load, load value. Outputs: done, running.
- The top level holds the FSM, the channel registers and the strobe decode.

Test Plan:
- Reset, then idle: o0..o3=0, stb=0, in_ready=1, busy=0.
- Single write, WIDTH=4, SETTLE_CYCLES=3: {s1,s0}=10, i=4'hA, valid for 1 cycle -> next cycle o2=A, stb=0100, others 0; in_ready low for exactly 3 cycles, then 1.
- Back-to-back requests: valid held with ch1=5 then ch3=C -> ch3 accepted only after 3 ready-low cycles; o1=5, o3=C; stb pulses 0010 then 1000; writes presented during settle are ignored.
- SETTLE_CYCLES=0: writes to channels 0,1,2,3 with values 1,2,3,4 on four consecutive cycles -> in_ready stays 1; outputs 1,2,3,4; stb walks 0001,0010,0100,1000.
- Reset mid-settle: accept ch0=F, assert rst on the 2nd settle cycle -> next cycle o0=0, in_ready=1, busy=0; a following write to ch0=6 is accepted immediately.
- Overwrite: ch2=3 then ch2=9 -> o2=9, two separate 0100 strobes, other channels unchanged.
